// File: rtl/grid_pkg.sv
// grid_pkg: constants and types shared by the grid output path.
// Row framing, load phase and the FIFO entry layout live here.
package grid_pkg;
    localparam int ROW_WORDS = 32;
    localparam int WORD_W = 64;
    localparam int ROW_W_DEF = 16;
    localparam logic [4:0] T_LOAD = 5'd1;

    typedef enum logic [1:0] {
        IDLE,
        CAP,
        DROP
    } cap_state_e;

    typedef struct packed {
        logic [ROW_W_DEF-1:0] row;
        logic last;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;
endpackage

// File: rtl/grid_word_fifo.sv
// grid_word_fifo: synchronous FIFO with first-word-fall-through output.
// The head word is driven straight from storage; reads pop it.
module grid_word_fifo #(
    parameter int W = 81,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0] count;
    logic rd_fire;

    assign rd_valid = (count != '0);
    assign rd_fire = rd_en && rd_valid;
    // Zero the head while empty so idle outputs read as 0.
    assign rd_data = rd_valid ? mem[rptr] : '0;
    assign level = count;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_fire) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({wr_en, rd_fire})
                2'b10: count <= count + (AW+1)'(1);
                2'b01: count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/grid_row_streamer.sv
// grid_row_streamer: frames serializer words into whole rows and buffers
// them; rows without room for all 32 words are dropped as a unit.
module grid_row_streamer
    import grid_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int ROW_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             t,
    input  logic [WORD_W-1:0]      result,
    input  logic                   run,
    output logic [WORD_W-1:0]      m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic [ROW_W-1:0]       m_row,
    output logic                   overflow,
    output logic                   sync_err,
    output logic [15:0]            drop_cnt,
    output logic [$clog2(DEPTH):0] level
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int EW = ROW_W + 1 + WORD_W;

    cap_state_e state_q;
    cap_state_e state_d;
    logic [4:0] t_q;
    logic [4:0] wcnt_q;
    logic [4:0] wcnt_d;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_d;
    logic [ROW_W-1:0] cur_q;
    logic [ROW_W-1:0] cur_d;
    logic [ROW_W-1:0] wr_row;
    logic ovf_q;
    logic ovf_d;
    logic serr_q;
    logic serr_d;
    logic [15:0] drop_q;
    logic [15:0] drop_d;
    logic start;
    logic room;
    logic wr_en;
    logic wr_last;
    logic [EW-1:0] wr_data;
    logic [EW-1:0] rd_data;

    assign start = (t_q == T_LOAD);
    // Admission looks at occupancy before this edge's read.
    assign room = (level <= LW'(DEPTH - ROW_WORDS));
    assign wr_data = {wr_row, wr_last, result};

    always_ff @(posedge clk) begin
        if (!rst) begin
            t_q <= '0;
            state_q <= IDLE;
            wcnt_q <= '0;
            row_q <= '0;
            cur_q <= '0;
            ovf_q <= 1'b0;
            serr_q <= 1'b0;
            drop_q <= '0;
        end else begin
            t_q <= t;
            state_q <= state_d;
            wcnt_q <= wcnt_d;
            row_q <= row_d;
            cur_q <= cur_d;
            ovf_q <= ovf_d;
            serr_q <= serr_d;
            drop_q <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d = wcnt_q;
        row_d = row_q;
        cur_d = cur_q;
        ovf_d = ovf_q;
        serr_d = serr_q;
        drop_d = drop_q;
        wr_en = 1'b0;
        wr_last = 1'b0;
        wr_row = cur_q;
        unique case (state_q)
            IDLE: begin
                if (start && run) begin
                    row_d = row_q + ROW_W'(1);
                    wcnt_d = 5'd1;
                    if (room) begin
                        wr_en = 1'b1;
                        wr_row = row_q;
                        cur_d = row_q;
                        state_d = CAP;
                    end else begin
                        ovf_d = 1'b1;
                        if (drop_q != 16'hFFFF) begin
                            drop_d = drop_q + 16'd1;
                        end
                        state_d = DROP;
                    end
                end
            end
            CAP, DROP: begin
                wr_en = (state_q == CAP);
                wr_last = (wcnt_q == 5'd31);
                if (start && wcnt_q != 5'd31) begin
                    serr_d = 1'b1;
                end
                wcnt_d = wcnt_q + 5'd1;
                if (wcnt_q == 5'd31) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    grid_word_fifo #(
        .W(EW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .rd_en(m_ready),
        .rd_data(rd_data),
        .rd_valid(m_valid),
        .level(level)
    );

    assign {m_row, m_last, m_data} = rd_data;
    assign overflow = ovf_q;
    assign sync_err = serr_q;
    assign drop_cnt = drop_q;
endmodule
